vend_ctrl_n: RTL
================

Name: vend_ctrl_n

Overview:
Parametrised vending-machine controller, the next generation of the 3-product Vending_Machine. It handles N products with per-product prices, coin credit accumulation, change return, cancel/refund, an inactivity timeout and per-product stock counting with sold-out flags. Seven-segment decoding of credit and change stays outside this block.

Parameters:
NUM_PROD, 3, number of products/buttons (1..8)
COIN_W, 3, coin value width (zl)
CREDIT_W, 5, credit/price/change width; must hold max price + max coin - 1
PRICES, {5'd5,5'd3,5'd2}, packed prices, product i at [i*CREDIT_W +: CREDIT_W]; each price must be nonzero
STOCK_W, 4, stock counter width
INIT_STOCK, 4'd3, stock loaded per product at reset and restock
TIMEOUT_CYC, 1000, idle cycles in PAY before auto-refund

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
btn  in  NUM_PROD  product select buttons, level sampled each cycle
coin_valid  in  1  one-cycle coin strobe
coin_value  in  COIN_W  value of the inserted coin
cancel  in  1  cancel/refund request
restock  in  1  reload all stock to INIT_STOCK (IDLE only)
coin_ready  out  1  high only in PAY; coins are ignored when low
selected  out  NUM_PROD  one-hot selected product (LEDs)
credit  out  CREDIT_W  current credit
product  out  NUM_PROD  one-hot one-cycle dispense pulse
delivered  out  1  one-cycle pulse, coincident with product
change_valid  out  1  one-cycle change/refund strobe
change_value  out  CREDIT_W  amount returned, valid with change_valid
sold_out  out  NUM_PROD  stock[i]==0

Behaviour:
- All outputs are registered. With reset=0 at a rising edge: state=IDLE, credit=0, selected=0, product=0, delivered=0, change_valid=0, change_value=0, timer=0, every stock=INIT_STOCK, sold_out=0 (unless INIT_STOCK=0). Reset takes effect from any state, mid-transaction included; accumulated credit is discarded and no refund is issued.
- States: IDLE, PAY, DISPENSE, CHANGE, REFUND.
- IDLE: coins, cancel and coin_ready are ignored. If any btn[i] is high with stock[i]>0, the lowest such index wins, is latched into selected, and the state moves to PAY on the next cycle. Buttons for sold-out products are ignored. restock reloads all counters; restock is ignored in other states.
- PAY: coin_ready=1. A coin_valid adds coin_value (zero-extended) to credit and clears timer. Otherwise timer increments.
  - If the new credit >= price[sel], go to DISPENSE.
  - If cancel is high, or timer reaches TIMEOUT_CYC-1, go to REFUND.
  - When cancel and a completing coin arrive in the same cycle, cancel wins and the refund includes that coin.
  - Buttons are ignored in PAY.
- DISPENSE (1 cycle): product[sel]=1, delivered=1, stock[sel] decrements (never below 0). If credit > price, go to CHANGE; otherwise credit clears, selected clears and the state returns to IDLE.
- CHANGE (1 cycle): change_valid=1, change_value=credit-price[sel]; credit and selected clear; go to IDLE.
- REFUND (1 cycle): change_valid=1, change_value=credit (0 allowed; the strobe is still issued); credit and selected clear; go to IDLE.
- Latency:
  - Button sampled at cycle t: selected visible at t+1.
  - Completing coin at t: product/delivered at t+1, change at t+2.
  - Cancel at t: refund at t+1.
- Arithmetic is unsigned. The CREDIT_W sizing rule guarantees no overflow. An elaboration-time check fails if it is violated or any price is 0.

Decomposition:
- Shared package vend_pkg holds the state enum (IDLE..REFUND), the price-slice extraction function, and the credit-width check constant.
- One sub-module, vend_stock_bank: NUM_PROD counters with a load (reset/restock) input, a one-hot decrement input, and sold_out outputs.
- The FSM, credit register and timer stay in vend_ctrl_n.

Test Plan:
- Tea exact: btn[0]=1, coin 2 -> product[0] and delivered pulse one cycle after the coin; no change_valid; credit returns to 0.
- Coffee with change: btn[1], coin 5 -> product[1] pulse, then change_valid with change_value=2 the next cycle.
- Hot chocolate in multiple coins: btn[2], coins 2, 2, 2 -> credit steps 2, 4, 6; dispense after the third coin; change_value=1.
- Cancel and timeout: btn[1], coin 1, cancel -> change_value=1, no product. Repeat with no cancel -> refund exactly TIMEOUT_CYC cycles after the last coin.
- Sold out and restock: vend product 0 three times -> sold_out[0]=1, btn[0] ignored (selected stays 0), btn[0]|btn[1] selects 1; restock in IDLE -> sold_out[0]=0.
- Reset and priority: reset=0 while in PAY with credit 3 -> IDLE, credit 0, no change_valid. Cancel together with a completing coin -> refund of the full amount, no product.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and elaboration helpers for the vending controller.
package vend_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPay,
      StDispense,
      StChange,
      StRefund
   } vend_state_e;

   // Upper bounds for the packed price vector handed to the helpers below.
   localparam int unsigned PricesMaxW = 128;
   localparam int unsigned MaxCreditW = 16;

   // Extract price slice idx (width bits wide) from the packed price vector.
   function automatic int unsigned price_of(input logic [PricesMaxW-1:0] prices,
                                            input int unsigned idx,
                                            input int unsigned width);
      logic [PricesMaxW-1:0] mask;
      logic [PricesMaxW-1:0] slice;
      mask  = (PricesMaxW'(1) << width) - PricesMaxW'(1);
      slice = (prices >> (idx * width)) & mask;
      return slice[31:0];
   endfunction

   // Credit must hold the largest price plus the largest coin minus one; prices nonzero.
   function automatic bit cfg_ok(input logic [PricesMaxW-1:0] prices,
                                 input int unsigned num_prod,
                                 input int unsigned coin_w,
                                 input int unsigned credit_w);
      int unsigned max_price;
      int unsigned p;
      if (num_prod < 1 || num_prod > 8) return 1'b0;
      if (credit_w > MaxCreditW || coin_w > MaxCreditW) return 1'b0;
      if (num_prod * credit_w > PricesMaxW) return 1'b0;
      max_price = 0;
      for (int unsigned i = 0; i < num_prod; i++) begin
         p = price_of(prices, i, credit_w);
         if (p == 0) return 1'b0;
         if (p > max_price) max_price = p;
      end
      return (max_price + ((1 << coin_w) - 1) - 1) < (1 << credit_w);
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with bulk load, one-hot decrement and sold-out flags.
module vend_stock_bank #(
   parameter int unsigned        NUM_PROD   = 3,
   parameter int unsigned        STOCK_W    = 4,
   parameter logic [STOCK_W-1:0] INIT_STOCK = STOCK_W'(3)
) (
   input  logic                clk_i,
   input  logic                load_i,
   input  logic [NUM_PROD-1:0] dec_i,
   output logic [NUM_PROD-1:0] sold_out_o
);

   logic [STOCK_W-1:0]  stock_q [NUM_PROD];
   logic [STOCK_W-1:0]  stock_d [NUM_PROD];
   logic [NUM_PROD-1:0] sold_out_q;

   // Next stock: load wins, decrement saturates at zero.
   always_comb begin
      for (int i = 0; i < NUM_PROD; i++) begin
         stock_d[i] = stock_q[i];
         if (load_i) begin
            stock_d[i] = INIT_STOCK;
         end else if (dec_i[i] && stock_q[i] != '0) begin
            stock_d[i] = stock_q[i] - 1'b1;
         end
      end
   end

   // Counters and registered sold-out flags; the load input doubles as reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_PROD; i++) begin
         stock_q[i]    <= stock_d[i];
         sold_out_q[i] <= (stock_d[i] == '0);
      end
   end

   assign sold_out_o = sold_out_q;

endmodule

// File: rtl/vend_ctrl_n.sv
// N-product vending controller: selection, coin credit, dispense, change, refund, timeout.
module vend_ctrl_n
   import vend_pkg::*;
#(
   parameter int unsigned                   NUM_PROD    = 3,
   parameter int unsigned                   COIN_W      = 3,
   parameter int unsigned                   CREDIT_W    = 5,
   parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICES      = {5'd5, 5'd3, 5'd2},
   parameter int unsigned                   STOCK_W     = 4,
   parameter logic [STOCK_W-1:0]            INIT_STOCK  = 4'd3,
   parameter int unsigned                   TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PROD-1:0] btn,
   input  logic                coin_valid,
   input  logic [COIN_W-1:0]   coin_value,
   input  logic                cancel,
   input  logic                restock,
   output logic                coin_ready,
   output logic [NUM_PROD-1:0] selected,
   output logic [CREDIT_W-1:0] credit,
   output logic [NUM_PROD-1:0] product,
   output logic                delivered,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_value,
   output logic [NUM_PROD-1:0] sold_out
);

   localparam bit          CfgOk  = cfg_ok(PricesMaxW'(PRICES), NUM_PROD, COIN_W, CREDIT_W);
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

   if (!CfgOk) begin : g_cfg_err
      $error("vend_ctrl_n: PRICES contains a zero price or CREDIT_W is too narrow");
   end

   vend_state_e         state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [NUM_PROD-1:0] selected_q;
   logic [NUM_PROD-1:0] product_q;
   logic                delivered_q;
   logic                change_valid_q;
   logic [CREDIT_W-1:0] change_value_q;
   logic                coin_ready_q;
   logic [TimerW-1:0]   timer_q;

   logic [CREDIT_W-1:0] price_sel;
   logic [CREDIT_W-1:0] credit_sum;
   logic [NUM_PROD-1:0] pick;
   logic                timed_out;
   logic                stock_load;
   logic [NUM_PROD-1:0] stock_dec;

   // Price of the latched product, new credit, and lowest-index available button.
   always_comb begin
      price_sel = '0;
      for (int i = 0; i < NUM_PROD; i++) begin
         if (selected_q[i]) begin
            price_sel = price_sel | CREDIT_W'(price_of(PricesMaxW'(PRICES), i, CREDIT_W));
         end
      end
      credit_sum = credit_q + (coin_valid ? CREDIT_W'(coin_value) : '0);
      pick = '0;
      for (int i = NUM_PROD - 1; i >= 0; i--) begin
         if (btn[i] && !sold_out[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
      timed_out  = !coin_valid && (timer_q == TimerW'(TIMEOUT_CYC - 1));
      stock_load = !reset || (state_q == StIdle && restock);
      stock_dec  = (state_q == StDispense) ? selected_q : '0;
   end

   // Main FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= StIdle;
         credit_q       <= '0;
         selected_q     <= '0;
         product_q      <= '0;
         delivered_q    <= 1'b0;
         change_valid_q <= 1'b0;
         change_value_q <= '0;
         coin_ready_q   <= 1'b0;
         timer_q        <= '0;
      end else begin
         product_q      <= '0;
         delivered_q    <= 1'b0;
         change_valid_q <= 1'b0;
         coin_ready_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               timer_q <= '0;
               if (pick != '0) begin
                  selected_q   <= pick;
                  coin_ready_q <= 1'b1;
                  state_q      <= StPay;
               end
            end
            StPay: begin
               credit_q <= credit_sum;
               timer_q  <= coin_valid ? '0 : timer_q + 1'b1;
               // Cancel beats a completing coin; the refund includes that coin.
               if (cancel || timed_out) begin
                  change_valid_q <= 1'b1;
                  change_value_q <= credit_sum;
                  state_q        <= StRefund;
               end else if (credit_sum >= price_sel) begin
                  product_q   <= selected_q;
                  delivered_q <= 1'b1;
                  state_q     <= StDispense;
               end else begin
                  coin_ready_q <= 1'b1;
               end
            end
            StDispense: begin
               if (credit_q > price_sel) begin
                  change_valid_q <= 1'b1;
                  change_value_q <= credit_q - price_sel;
                  state_q        <= StChange;
               end else begin
                  credit_q   <= '0;
                  selected_q <= '0;
                  state_q    <= StIdle;
               end
            end
            StChange, StRefund: begin
               credit_q   <= '0;
               selected_q <= '0;
               state_q    <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   vend_stock_bank #(
      .NUM_PROD   (NUM_PROD),
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
   ) u_stock (
      .clk_i      (clk),
      .load_i     (stock_load),
      .dec_i      (stock_dec),
      .sold_out_o (sold_out)
   );

   assign coin_ready   = coin_ready_q;
   assign selected     = selected_q;
   assign credit       = credit_q;
   assign product      = product_q;
   assign delivered    = delivered_q;
   assign change_valid = change_valid_q;
   assign change_value = change_value_q;

endmodule
